message_overlay: RTL

Parametrised successor to the single-message end-of-game text overlay. It draws one of NUM_MSGS bitmap messages, for example GAME OVER, YOU WIN or READY, from an external synchronous ROM. Each message is scaled by a power of two and placed at a parametrised screen position. Display is either timed or latched until dismissed, with retrigger and one-cycle completion pulse; sits between game FSM and the VGA pixel mux.

---
 rtl/message_overlay_if.sv | 31 +++
 rtl/message_overlay.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/message_overlay_if.sv
// Bus bundle for message_overlay: game-FSM control, VGA pixel coordinates,
// external synchronous message ROM port and overlay/status outputs.
interface message_overlay_if #(
    parameter int NUM_MSGS = 4,
    parameter int MSG_W    = 32,
    parameter int MSG_H    = 16
);
    localparam int SEL_W  = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
    localparam int ADDR_W = (NUM_MSGS * MSG_H > 1) ? $clog2(NUM_MSGS * MSG_H) : 1;

    logic              trigger;
    logic [SEL_W-1:0]  msg_sel;
    logic              dismiss;
    logic [9:0]        pixel_x;
    logic [8:0]        pixel_y;
    logic [ADDR_W-1:0] rom_addr;
    logic [MSG_W-1:0]  rom_data;
    logic              overlay_on;
    logic              busy;
    logic              done;

    modport master (
        output trigger, msg_sel, dismiss, pixel_x, pixel_y, rom_data,
        input  rom_addr, overlay_on, busy, done
    );

    modport slave (
        input  trigger, msg_sel, dismiss, pixel_x, pixel_y, rom_data,
        output rom_addr, overlay_on, busy, done
    );
endinterface

// File: rtl/message_overlay.sv
// Scaled bitmap message overlay with timed or latched display.
// Optional blinking text is enabled by defining MSG_BLINK_EN.
module message_overlay #(
    parameter int NUM_MSGS       = 4,
    parameter int MSG_W          = 32,
    parameter int MSG_H          = 16,
    parameter int SCALE_SHIFT    = 3,
    parameter int START_X        = 230,
    parameter int START_Y        = 160,
    parameter int DISPLAY_CYCLES = 250000000,
    parameter int BLINK_CYCLES   = 12500000
) (
    input logic              clk,
    input logic              reset_n,
    message_overlay_if.slave bus
);
    localparam int SEL_W  = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
    localparam int ADDR_W = (NUM_MSGS * MSG_H > 1) ? $clog2(NUM_MSGS * MSG_H) : 1;
    localparam int COL_W  = (MSG_W > 1) ? $clog2(MSG_W) : 1;
    localparam int ROW_W  = (MSG_H > 1) ? $clog2(MSG_H) : 1;
    localparam logic signed [10:0] WIN_W = 11'(MSG_W << SCALE_SHIFT);
    localparam logic signed [10:0] WIN_H = 11'(MSG_H << SCALE_SHIFT);
    localparam logic [31:0] LAST_TICK = 32'(DISPLAY_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

    state_t            state;
    logic [31:0]       timer;
    logic [SEL_W-1:0]  msg_q;
    logic [SEL_W-1:0]  sel_clamped;
    logic              busy_q;
    logic              done_q;

    logic signed [10:0] rel_x;
    logic signed [10:0] rel_y;
    logic               in_win;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ROW_W-1:0]   row_eff;

    logic               in_win_q;
    logic               show_q;
    logic [COL_W-1:0]   col_q;
    logic [COL_W-1:0]   bit_idx;

    assign sel_clamped = (32'(bus.msg_sel) >= 32'(NUM_MSGS)) ? SEL_W'(NUM_MSGS - 1) : bus.msg_sel;

    // Trigger wins over everything else and always (re)starts a fresh display.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            timer  <= '0;
            msg_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.trigger) begin
                state  <= SHOW;
                msg_q  <= sel_clamped;
                timer  <= '0;
                busy_q <= 1'b1;
            end else begin
                case (state)
                    SHOW: begin
                        if (bus.dismiss) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else if (DISPLAY_CYCLES > 0) begin
                            if (timer == LAST_TICK) begin
                                state  <= DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                timer  <= '0;
                            end else begin
                                timer <= timer + 32'd1;
                            end
                        end
                    end
                    DONE: begin
                        if (bus.dismiss) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Window test runs on the full signed offsets so off-window pixels never alias in.
    assign rel_x   = $signed({1'b0, bus.pixel_x}) - 11'(START_X);
    assign rel_y   = $signed({2'b00, bus.pixel_y}) - 11'(START_Y);
    assign in_win  = (rel_x >= 11'sd0) && (rel_x < WIN_W) &&
                     (rel_y >= 11'sd0) && (rel_y < WIN_H);
    assign col     = COL_W'(rel_x >> SCALE_SHIFT);
    assign row     = ROW_W'(rel_y >> SCALE_SHIFT);
    assign row_eff = in_win ? row : '0;

    assign bus.rom_addr = ADDR_W'(msg_q) * ADDR_W'(MSG_H) + ADDR_W'(row_eff);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_win_q <= 1'b0;
            show_q   <= 1'b0;
            col_q    <= '0;
        end else begin
            in_win_q <= in_win;
            show_q   <= (state == SHOW);
            col_q    <= col;
        end
    end

    assign bit_idx = COL_W'(MSG_W - 1) - col_q;

`ifdef MSG_BLINK_EN
    logic [31:0] blink_cnt;
    logic        blink_vis;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (bus.trigger) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (state == SHOW) begin
            if (blink_cnt == 32'(BLINK_CYCLES - 1)) begin
                blink_cnt <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end
        end
    end

    assign bus.overlay_on = show_q & in_win_q & bus.rom_data[bit_idx] & blink_vis;
`else
    assign bus.overlay_on = show_q & in_win_q & bus.rom_data[bit_idx];
`endif

endmodule
